// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus interface stage: bus widths, the
// error fill pattern and the access state machine encoding.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 20;
  localparam int MEM_DATA_W = 16;

  localparam logic [MEM_DATA_W-1:0] MEM_ERR_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_ACK
  } bus_state_t;

endpackage

// File: rtl/mem_bus_if.sv
// Memory bus interface: turns a four-phase request from execute into one
// registered SRAM-style access with wait states, ready stretch and timeout.
module mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rqm_n,
  input  logic                  rwm_n,
  input  logic [MEM_ADDR_W-1:0] adm_n,
  input  logic [MEM_DATA_W-1:0] dwm_n,
  output logic                  akm_n,
  output logic [MEM_DATA_W-1:0] drm_n,
  output logic                  mem_err,
  output logic [MEM_ADDR_W-1:0] ext_addr,
  output logic [MEM_DATA_W-1:0] ext_dout,
  input  logic [MEM_DATA_W-1:0] ext_din,
  output logic                  ext_dq_oe,
  output logic                  ext_ce_n,
  output logic                  ext_oe_n,
  output logic                  ext_we_n,
  input  logic                  ext_rdy
);

  localparam logic [3:0] WAIT_LOAD     = 4'(WAIT_STATES);
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

  bus_state_t state, state_next;

  logic [3:0] wait_cnt;
  logic [7:0] to_cnt;
  logic [8:0] to_inc;
  logic       is_read;
  logic       access_done;
  logic       access_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Completion takes priority over a timeout landing on the same edge.
  always_comb begin
    state_next     = state;
    access_done    = 1'b0;
    access_timeout = 1'b0;
    to_inc         = {1'b0, to_cnt} + 9'd1;
    case (state)
      ST_IDLE:   if (rqm_n) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (wait_cnt == 4'd0 && ext_rdy) begin
          access_done = 1'b1;
        end else if (TIMEOUT_LIMIT != 9'd0 && to_inc == TIMEOUT_LIMIT) begin
          access_timeout = 1'b1;
        end
        if (access_done || access_timeout) state_next = ST_HOLD;
      end
      ST_HOLD:   state_next = ST_ACK;
      ST_ACK:    if (!rqm_n) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Every output is a register loaded on the edge that enters the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      akm_n     <= 1'b0;
      drm_n     <= '0;
      mem_err   <= 1'b0;
      ext_addr  <= '0;
      ext_dout  <= '0;
      ext_dq_oe <= 1'b0;
      ext_ce_n  <= 1'b1;
      ext_oe_n  <= 1'b1;
      ext_we_n  <= 1'b1;
      wait_cnt  <= 4'd0;
      to_cnt    <= 8'd0;
      is_read   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rqm_n) begin
            is_read   <= rwm_n;
            ext_addr  <= adm_n;
            ext_ce_n  <= 1'b0;
            ext_dq_oe <= ~rwm_n;
            mem_err   <= 1'b0;
            if (!rwm_n) ext_dout <= dwm_n;
          end
        end
        ST_SETUP: begin
          ext_oe_n <= ~is_read;
          ext_we_n <= is_read;
          wait_cnt <= WAIT_LOAD;
          to_cnt   <= 8'd0;
        end
        ST_ACCESS: begin
          to_cnt <= to_inc[7:0];
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          if (access_done && is_read) drm_n <= ext_din;
          if (access_timeout) begin
            mem_err <= 1'b1;
            if (is_read) drm_n <= MEM_ERR_DATA;
          end
          if (access_done || access_timeout) begin
            ext_oe_n <= 1'b1;
            ext_we_n <= 1'b1;
          end
        end
        ST_HOLD: begin
          akm_n     <= 1'b1;
          ext_ce_n  <= 1'b1;
          ext_dq_oe <= 1'b0;
        end
        ST_ACK: begin
          if (!rqm_n) akm_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
